// File: rtl/iq_ddc_pkg.sv
// Shared helpers for the IQ down-converter: CIC width, LO table entries,
// and the rounding shifter / saturation used on the outputs.
package iq_ddc_pkg;

  localparam int  SCALE_W = 128;
  localparam real PI      = 3.14159265358979323846;

  function automatic int cic_width(input int in_w, input int lo_w,
                                   input int order, input int fac_w);
    return in_w + lo_w + order * fac_w;
  endfunction

  // Round-to-nearest (ties away from zero) so tiny residues at the
  // quarter-wave points resolve to exactly zero.
  function automatic int lo_entry(input int k, input int addr_w,
                                  input int lo_w, input bit neg_sin);
    real peak;
    real ang;
    real v;
    peak = $itor((1 << (lo_w - 1)) - 1);
    ang  = 2.0 * PI * $itor(k) / $itor(1 << addr_w);
    v    = neg_sin ? -peak * $sin(ang) : peak * $cos(ang);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [SCALE_W-1:0] round_shift(
      input logic signed [SCALE_W-1:0] c, input logic [5:0] sh);
    logic signed [SCALE_W-1:0] bias;
    bias = (sh == 6'd0) ? '0 : (SCALE_W'(1) << (sh - 6'd1));
    return (c + bias) >>> sh;
  endfunction

  function automatic logic signed [SCALE_W-1:0] sat_hi(input int out_w);
    return (SCALE_W'(1) << (out_w - 1)) - SCALE_W'(1);
  endfunction

  function automatic logic sat_hit(input logic signed [SCALE_W-1:0] y,
                                   input int out_w);
    logic signed [SCALE_W-1:0] hi;
    hi = sat_hi(out_w);
    return (y > hi) || (y < ~hi);
  endfunction

  function automatic logic signed [SCALE_W-1:0] sat_clamp(
      input logic signed [SCALE_W-1:0] y, input int out_w);
    logic signed [SCALE_W-1:0] hi;
    hi = sat_hi(out_w);
    if (y > hi) return hi;
    if (y < ~hi) return ~hi;
    return y;
  endfunction

endpackage

// File: rtl/iq_lo_lut.sv
// Complex LO table: phase address in, registered (cos, -sin) out,
// one cycle of latency.
module iq_lo_lut
  import iq_ddc_pkg::*;
#(
  parameter int LO_WIDTH       = 12,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                      clk_in,
  input  logic [LUT_ADDR_WIDTH-1:0] phase,
  output logic [LO_WIDTH-1:0]       lo_cos,
  output logic [LO_WIDTH-1:0]       lo_nsin
);

  localparam int DEPTH = 1 << LUT_ADDR_WIDTH;

  logic [LO_WIDTH-1:0] cos_rom  [DEPTH];
  logic [LO_WIDTH-1:0] nsin_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign cos_rom[k]  = LO_WIDTH'(lo_entry(k, LUT_ADDR_WIDTH, LO_WIDTH, 1'b0));
    assign nsin_rom[k] = LO_WIDTH'(lo_entry(k, LUT_ADDR_WIDTH, LO_WIDTH, 1'b1));
  end

  always_ff @(posedge clk_in) begin
    lo_cos  <= cos_rom[phase];
    lo_nsin <= nsin_rom[phase];
  end

endmodule

// File: rtl/iq_ddc_cic.sv
// IQ down-converter: LUT LO mixer, CIC_ORDER-stage CIC decimator, rounding
// output shifter. Define IQ_DDC_SAT_EN for clamped outputs and sat_flag.
module iq_ddc_cic
  import iq_ddc_pkg::*;
#(
  parameter int INPUT_WIDTH    = 12,
  parameter int LO_WIDTH       = 12,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int CIC_ORDER      = 3,
  parameter int FACTOR_WIDTH   = 16,
  parameter int OUTPUT_WIDTH   = 16
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic                    cfg_load,
  input  logic [FACTOR_WIDTH-1:0] FACTOR,
  input  logic [PHASE_WIDTH-1:0]  Fre_word,
  input  logic [PHASE_WIDTH-1:0]  phase_offset,
  input  logic [5:0]              out_shift,
  input  logic                    valid_in,
  input  logic [INPUT_WIDTH-1:0]  wave_in,
  output logic                    valid_out,
  output logic [OUTPUT_WIDTH-1:0] I_OUT,
  output logic [OUTPUT_WIDTH-1:0] Q_OUT,
  output logic                    sat_flag
);

  localparam int CIC_WIDTH  = cic_width(INPUT_WIDTH, LO_WIDTH, CIC_ORDER, FACTOR_WIDTH);
  localparam int PROD_WIDTH = INPUT_WIDTH + LO_WIDTH;

  logic [FACTOR_WIDTH-1:0] factor_r;
  logic [PHASE_WIDTH-1:0]  fre_r;
  logic [5:0]              shift_r;
  logic [PHASE_WIDTH-1:0]  phase;
  logic                    accept;

  assign accept = valid_in & ~cfg_load;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      factor_r <= FACTOR_WIDTH'(1);
      fre_r    <= '0;
      shift_r  <= '0;
      phase    <= '0;
    end else if (cfg_load) begin
      factor_r <= (FACTOR == '0) ? FACTOR_WIDTH'(1) : FACTOR;
      fre_r    <= Fre_word;
      shift_r  <= out_shift;
      phase    <= phase_offset;
    end else if (accept) begin
      phase <= phase + fre_r;
    end
  end

  // Stage 1: LO lookup alongside the delayed sample
  logic [LO_WIDTH-1:0]           lo_cos, lo_nsin;
  logic signed [INPUT_WIDTH-1:0] x_d1;
  logic                          v1;

  iq_lo_lut #(
    .LO_WIDTH      (LO_WIDTH),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH)
  ) u_lut (
    .clk_in (clk_in),
    .phase  (phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]),
    .lo_cos (lo_cos),
    .lo_nsin(lo_nsin)
  );

  // Stage 2: full-width products
  logic signed [PROD_WIDTH-1:0] prod_i, prod_q;
  logic                         v2;

  always_ff @(posedge clk_in) begin
    x_d1   <= $signed(wave_in);
    prod_i <= PROD_WIDTH'(x_d1) * PROD_WIDTH'($signed(lo_cos));
    prod_q <= PROD_WIDTH'(x_d1) * PROD_WIDTH'($signed(lo_nsin));
    if (RST || cfg_load) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
    end
  end

  // Integrators: wrap-around arithmetic is intentional
  logic signed [CIC_WIDTH-1:0] int_i [CIC_ORDER];
  logic signed [CIC_WIDTH-1:0] int_q [CIC_ORDER];
  logic                        iv    [CIC_ORDER];

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_int
    logic signed [CIC_WIDTH-1:0] src_i, src_q;
    logic                        src_v;
    if (k == 0) begin : g_first
      assign src_i = CIC_WIDTH'(prod_i);
      assign src_q = CIC_WIDTH'(prod_q);
      assign src_v = v2;
    end else begin : g_next
      assign src_i = int_i[k-1];
      assign src_q = int_q[k-1];
      assign src_v = iv[k-1];
    end
    always_ff @(posedge clk_in) begin
      if (RST || cfg_load) begin
        int_i[k] <= '0;
        int_q[k] <= '0;
        iv[k]    <= 1'b0;
      end else begin
        iv[k] <= src_v;
        if (src_v) begin
          int_i[k] <= int_i[k] + src_i;
          int_q[k] <= int_q[k] + src_q;
        end
      end
    end
  end

  // Decimator: pass every R-th integrator output
  logic [FACTOR_WIDTH-1:0]     dec_cnt;
  logic                        dec_v;
  logic signed [CIC_WIDTH-1:0] dec_i, dec_q;

  always_ff @(posedge clk_in) begin
    if (RST || cfg_load) begin
      dec_cnt <= '0;
      dec_v   <= 1'b0;
    end else begin
      dec_v <= 1'b0;
      if (iv[CIC_ORDER-1]) begin
        if (dec_cnt == factor_r - FACTOR_WIDTH'(1)) begin
          dec_cnt <= '0;
          dec_v   <= 1'b1;
          dec_i   <= int_i[CIC_ORDER-1];
          dec_q   <= int_q[CIC_ORDER-1];
        end else begin
          dec_cnt <= dec_cnt + FACTOR_WIDTH'(1);
        end
      end
    end
  end

  // Combs, differential delay 1
  logic signed [CIC_WIDTH-1:0] comb_i [CIC_ORDER];
  logic signed [CIC_WIDTH-1:0] comb_q [CIC_ORDER];
  logic signed [CIC_WIDTH-1:0] dly_i  [CIC_ORDER];
  logic signed [CIC_WIDTH-1:0] dly_q  [CIC_ORDER];
  logic                        cv     [CIC_ORDER];

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    logic signed [CIC_WIDTH-1:0] src_i, src_q;
    logic                        src_v;
    if (k == 0) begin : g_first
      assign src_i = dec_i;
      assign src_q = dec_q;
      assign src_v = dec_v;
    end else begin : g_next
      assign src_i = comb_i[k-1];
      assign src_q = comb_q[k-1];
      assign src_v = cv[k-1];
    end
    always_ff @(posedge clk_in) begin
      if (RST || cfg_load) begin
        comb_i[k] <= '0;
        comb_q[k] <= '0;
        dly_i[k]  <= '0;
        dly_q[k]  <= '0;
        cv[k]     <= 1'b0;
      end else begin
        cv[k] <= src_v;
        if (src_v) begin
          comb_i[k] <= src_i - dly_i[k];
          comb_q[k] <= src_q - dly_q[k];
          dly_i[k]  <= src_i;
          dly_q[k]  <= src_q;
        end
      end
    end
  end

  function automatic logic [OUTPUT_WIDTH-1:0] scale_out(input logic signed [CIC_WIDTH-1:0] c);
`ifdef IQ_DDC_SAT_EN
    return OUTPUT_WIDTH'(sat_clamp(round_shift(SCALE_W'(c), shift_r), OUTPUT_WIDTH));
`else
    return OUTPUT_WIDTH'(round_shift(SCALE_W'(c), shift_r));
`endif
  endfunction

  // Output stage: the first CIC_ORDER strobes carry comb start-up garbage
  logic [2:0] mask_cnt;
  logic       mask_done, out_fire;

  assign mask_done = (mask_cnt == 3'(CIC_ORDER));
  assign out_fire  = cv[CIC_ORDER-1] & mask_done;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      valid_out <= 1'b0;
      I_OUT     <= '0;
      Q_OUT     <= '0;
      mask_cnt  <= '0;
    end else if (cfg_load) begin
      valid_out <= 1'b0;
      mask_cnt  <= '0;
    end else begin
      valid_out <= out_fire;
      if (cv[CIC_ORDER-1] && !mask_done) mask_cnt <= mask_cnt + 3'd1;
      if (out_fire) begin
        I_OUT <= scale_out(comb_i[CIC_ORDER-1]);
        Q_OUT <= scale_out(comb_q[CIC_ORDER-1]);
      end
    end
  end

`ifdef IQ_DDC_SAT_EN
  function automatic logic clips(input logic signed [CIC_WIDTH-1:0] c);
    return sat_hit(round_shift(SCALE_W'(c), shift_r), OUTPUT_WIDTH);
  endfunction

  always_ff @(posedge clk_in) begin
    if (RST || cfg_load)
      sat_flag <= 1'b0;
    else if (out_fire)
      sat_flag <= sat_flag | clips(comb_i[CIC_ORDER-1]) | clips(comb_q[CIC_ORDER-1]);
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_iq_ddc_cic.sv
// Self-checking bench for iq_ddc_cic: vector table plus scoreboard of
// expected strobes (cycle, I, Q), and hand-written reload/reset sequences.
module tb_iq_ddc_cic;

  localparam int N = 3;
`ifdef IQ_DDC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_load = 1'b0;
  logic [15:0] FACTOR = '0;
  logic [31:0] Fre_word = '0;
  logic [31:0] phase_offset = '0;
  logic [5:0]  out_shift = '0;
  logic        valid_in = 1'b0;
  logic [11:0] wave_in = '0;
  logic        valid_out;
  logic [15:0] I_OUT;
  logic [15:0] Q_OUT;
  logic        sat_flag;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; int i; int q; } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          fac;
    logic [31:0] fre;
    logic [31:0] off;
    int          sh;
    int          x;
    int          gap;
    int          ei;
    int          eq;
    bit          esat;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  iq_ddc_cic dut (
    .clk_in      (clk_in),
    .RST         (RST),
    .cfg_load    (cfg_load),
    .FACTOR      (FACTOR),
    .Fre_word    (Fre_word),
    .phase_offset(phase_offset),
    .out_shift   (out_shift),
    .valid_in    (valid_in),
    .wave_in     (wave_in),
    .valid_out   (valid_out),
    .I_OUT       (I_OUT),
    .Q_OUT       (Q_OUT),
    .sat_flag    (sat_flag)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (valid_out) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", valid_out, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("I_OUT", longint'($signed(I_OUT)), e.i);
        check("Q_OUT", longint'($signed(Q_OUT)), e.q);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic scramble_cfg();
    FACTOR       = 16'($urandom);
    Fre_word     = $urandom;
    phase_offset = $urandom;
    out_shift    = 6'($urandom);
  endtask

  task automatic do_cfg(input int fac, input logic [31:0] fre, input logic [31:0] off,
                        input int sh, input bit with_valid);
    cfg_load     = 1'b1;
    FACTOR       = 16'(fac);
    Fre_word     = fre;
    phase_offset = off;
    out_shift    = 6'(sh);
    valid_in     = with_valid;
    wave_in      = 12'd100;
    tick();
    cfg_load = 1'b0;
    valid_in = 1'b0;
    scramble_cfg();
  endtask

  // Outputs whose final register update would land on or after the edge
  // following the last sample are dropped when cut is set (flush follows).
  task automatic run(input int x, input int reff, input int gap, input int nsamp,
                     input int ei, input int eq, input bit cut);
    int lim;
    exp_t e;
    lim = cyc + nsamp * (gap + 1);
    for (int s = 1; s <= nsamp; s++) begin
      for (int g = 0; g < gap; g++) begin
        valid_in = 1'b0;
        wave_in  = 12'($urandom);
        tick();
      end
      valid_in = 1'b1;
      wave_in  = 12'(x);
      if ((s % reff == 0) && (s / reff > N) && (!cut || (cyc + 9 < lim))) begin
        e.cyc = cyc + 2 * N + 4;
        e.i   = ei;
        e.q   = eq;
        sbq.push_back(e);
      end
      scramble_cfg();
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    check("drain_pending", sbq.size(), 0);
    repeat (12) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int reff;
    vt[0] = '{4, 32'd0, 32'd0,           10, 100,   0, 12794,                 0,      1'b0};
    vt[1] = '{4, 32'd0, 32'd0,           0,  100,   0, SAT ? 32767 : -6400,   0,      SAT};
    vt[2] = '{4, 32'd0, 32'h4000_0000,   10, 100,   0, 0,                     -12794, 1'b0};
    vt[3] = '{4, 32'h4000_0000, 32'd0,   10, 100,   0, 0,                     0,      1'b0};
    vt[4] = '{4, 32'd0, 32'd0,           10, 100,   2, 12794,                 0,      1'b0};
    vt[5] = '{0, 32'd0, 32'd0,           4,  -5,    0, -640,                  0,      1'b0};
    vt[6] = '{2, 32'd0, 32'd0,           3,  -2000, 0, SAT ? -32768 : -30768, 0,      SAT};

    repeat (3) tick();
    check("rst_valid_out", valid_out, 0);
    check("rst_I_OUT", I_OUT, 0);
    check("rst_Q_OUT", Q_OUT, 0);
    check("rst_sat_flag", sat_flag, 0);
    RST = 1'b0;

    for (int v = 0; v < NV; v++) begin
      reff = (vt[v].fac == 0) ? 1 : vt[v].fac;
      do_cfg(vt[v].fac, vt[v].fre, vt[v].off, vt[v].sh, 1'b0);
      run(vt[v].x, reff, vt[v].gap, reff * (N + 3), vt[v].ei, vt[v].eq, 1'b0);
      drain();
      check("hold_I_OUT", longint'($signed(I_OUT)), vt[v].ei);
      check("hold_Q_OUT", longint'($signed(Q_OUT)), vt[v].eq);
      check("vec_sat_flag", sat_flag, vt[v].esat);
    end

    // Reload mid-stream, coincident with a valid sample that must be dropped
    do_cfg(4, 32'd0, 32'd0, 0, 1'b0);
    run(100, 4, 0, 40, vt[1].ei, 0, 1'b1);
    check("sat_before_load", sat_flag, SAT);
    do_cfg(4, 32'd0, 32'd0, 11, 1'b1);
    check("sat_after_load", sat_flag, 0);
    check("no_strobe_after_load", valid_out, 0);
    run(100, 4, 0, 30, 6397, 0, 1'b1);

    // Synchronous reset mid-run
    RST      = 1'b1;
    valid_in = 1'b1;
    wave_in  = 12'd100;
    tick();
    check("midrst_valid_out", valid_out, 0);
    check("midrst_I_OUT", I_OUT, 0);
    check("midrst_Q_OUT", Q_OUT, 0);
    check("midrst_sat_flag", sat_flag, 0);
    RST      = 1'b0;
    valid_in = 1'b0;
    check("queue_after_reset", sbq.size(), 0);

    // Reset config defaults: R=1, Fre_word=0, shift=0
    run(3, 1, 0, 8, 6141, 0, 1'b0);
    drain();
    check("post_rst_hold_I", longint'($signed(I_OUT)), 6141);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_ddc_cic.md
Name: iq_ddc_cic

Overview:
Parametrised IQ digital down-converter. It mixes a real sample stream with an internal LUT-based complex LO and decimates I and Q through an N-order CIC with a runtime decimation factor. The outputs pass through a programmable rounding shifter. It is the successor to the fixed 3-stage Cordic/CIC mixer and sits in the Communicate/Demodulate path ahead of the demodulators. New relative to that block: a valid handshake, phase offset, atomic config load with flush, settling masking and output scaling.

Parameters:
INPUT_WIDTH, 12, signed sample width
LO_WIDTH, 12, signed LO amplitude width; peak = 2^(LO_WIDTH-1)-1
PHASE_WIDTH, 32, phase accumulator width
LUT_ADDR_WIDTH, 10, LO table address bits (top bits of phase)
CIC_ORDER, 3, integrator/comb stage count (1..6)
FACTOR_WIDTH, 16, decimation factor width
OUTPUT_WIDTH, 16, signed I/Q output width
Derived localparam CIC_WIDTH = INPUT_WIDTH+LO_WIDTH+CIC_ORDER*FACTOR_WIDTH (72 by default).

Ports:
clk_in  in  1  sole clock
RST  in  1  synchronous, active-high reset
cfg_load  in  1  one-cycle pulse; capture the config inputs below
FACTOR  in  FACTOR_WIDTH  decimation factor R; 0 is treated as 1
Fre_word  in  PHASE_WIDTH  LO phase increment per accepted sample
phase_offset  in  PHASE_WIDTH  LO phase at the first sample after a load
out_shift  in  6  arithmetic right shift applied before output
valid_in  in  1  wave_in is valid this cycle
wave_in  in  INPUT_WIDTH  signed sample
valid_out  out  1  one-cycle strobe; I_OUT/Q_OUT are new
I_OUT  out  OUTPUT_WIDTH  signed in-phase result
Q_OUT  out  OUTPUT_WIDTH  signed quadrature result
sat_flag  out  1  sticky overflow indicator (see Optional Feature)

Behaviour:
- Clocking and reset: single clock domain clk_in. RST is synchronous and active-high. All state clears on RST: valid_out=0, I_OUT=0, Q_OUT=0, sat_flag=0.
- Config registers on reset: factor_r=1, fre_r=0, offset_r=0, shift_r=0.
- cfg_load: on the cycle cfg_load=1, the config registers capture the inputs and the block soft-flushes everything except config:
  - phase accumulator loads offset value;
  - integrators, combs, pipeline valid bits, decimation counter and mask counter clear;
  - sat_flag clears.
- cfg_load with valid_in in the same cycle: cfg_load wins and the sample is dropped.
- Phase: sample n after reset or load uses phase P(n) = offset_r + n*fre_r, modulo 2^PHASE_WIDTH. The accumulator advances only on accepted valid_in.
- LO table: full-wave table of 2^LUT_ADDR_WIDTH entries, addressed by P[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH].
  - cos entry = round(peak*cos(2*pi*k/2^LUT_ADDR_WIDTH)).
  - LO output pair is (cos, -sin), giving I = x*cos and Q = -x*sin.
- Pipeline, valid-tagged, one register per stage:
  - stage 1: LUT read and sample delay;
  - stage 2: full-width product, INPUT_WIDTH+LO_WIDTH bits, sign-extended to CIC_WIDTH;
  - stages 3..: CIC_ORDER integrators, each updating only on its tagged valid;
  - decimation counter: counts integrator-output valids 0..R-1 and emits a strobe at R-1;
  - CIC_ORDER comb stages (differential delay 1), each updating on its strobe;
  - output scaler.
- Integrator and comb arithmetic wraps modulo 2^CIC_WIDTH. This is required for correctness.
- Output scaler: y = (c + 2^(shift-1)) >>> shift, with no rounding term when shift=0. The result is then reduced to OUTPUT_WIDTH per the Optional Feature.
- Latency: valid_out rises exactly 2*CIC_ORDER+4 cycles after the valid_in cycle of the R-th sample of a decimation group.
- Settling: after reset or load, the first CIC_ORDER decimated strobes are masked and valid_out stays 0. The first valid_out therefore follows sample (CIC_ORDER+1)*R.
- I_OUT/Q_OUT hold their value between strobes.
- valid_in may be sparse or continuous. With R=1, valid_out equals the delayed valid_in after settling.
- Changing FACTOR, Fre_word, offset or shift without cfg_load has no effect.

Optional Feature:
Macro IQ_DDC_SAT_EN.
- Defined: y is clamped to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]. sat_flag sets on any clamp of I or Q and is sticky until RST or cfg_load.
- Undefined: y is truncated to its low OUTPUT_WIDTH bits (wrap), and sat_flag is tied to 0.

Decomposition:
- Package iq_ddc_pkg holds:
  - CIC_WIDTH computation function;
  - LO table generation function (elaborated as a constant);
  - shared shift/saturate function.
- One sub-module, iq_lo_lut: phase in, registered cos/-sin out, one-cycle latency.
- The CIC_ORDER loops are generate loops inside iq_ddc_cic.

Test Plan:
1. Constant-input gain: cfg R=4, Fre_word=0, offset=0, shift=10; wave_in=100 continuous -> first valid_out at cycle 16+10 after load; I_OUT=12794, Q_OUT=0, then a new strobe every 4 cycles.
2. Overflow: same stimulus with shift=0 -> with IQ_DDC_SAT_EN, I_OUT=32767 and sat_flag=1; without it, I_OUT=-6400 and sat_flag=0.
3. Phase offset: offset=2^30, Fre_word=0, shift=10, wave_in=100 -> I_OUT=0, Q_OUT=-12794.
4. Fs/4 rejection: Fre_word=2^30, R=4, wave_in=100 -> every unmasked output has I_OUT=0 and Q_OUT=0.
5. Sparse valid: valid_in every 3rd cycle, R=4 -> valid_out period 12 cycles; values identical to scenario 1.
6. Mid-stream reconfiguration: cfg_load at cycle 40 with valid_in=1 -> sample dropped, no valid_out until sample 16 after the load, sat_flag cleared. Repeat with RST mid-run -> all outputs 0 the next cycle.
